mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/vDFFE.sv | 19 +
 rtl/mem_arbiter.sv | 112 +++++++++++
 tb/tb_mem_arbiter.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared memory-bus definitions: bus command encodings, arbiter FSM state
// encodings and a small request-decode helper. Imported by the arbiter and
// by anything that talks to the shared bus.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    M_NONE  = 2'b00,
    M_READ  = 2'b01,
    M_WRITE = 2'b10
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  // Only READ and WRITE are real requests; 2'b11 is treated like M_NONE.
  function automatic logic is_req(input logic [1:0] cmd);
    return (cmd == M_READ) || (cmd == M_WRITE);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the requester-side and bus-side signals of mem_arbiter.
//   r0_*/r1_*  : requester command/address/write data in, done/read data out
//   m_*        : shared memory/I/O bus (command, address, write data out,
//                read data in one cycle after the address)
//   owner/busy : arbitration status
// Handshake: a requester raises rK_cmd (READ or WRITE) with addr/wdata and
// holds all three stable until it samples rK_done high for one cycle; on that
// same edge it may drop or change the request. rK_rdata is valid from the
// cycle after done and holds until the requester's next read completes.
// modport master: the arbiter's view. modport slave: requesters + memory.
interface mem_arbiter_if #(
  parameter int DW = 16,
  parameter int AW = 9
);
  logic [1:0]    r0_cmd;
  logic [1:0]    r1_cmd;
  logic [AW-1:0] r0_addr;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r0_wdata;
  logic [DW-1:0] r1_wdata;
  logic          r0_done;
  logic          r1_done;
  logic [DW-1:0] r0_rdata;
  logic [DW-1:0] r1_rdata;
  logic [1:0]    m_cmd;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          owner;
  logic          busy;

  modport master (
    input  r0_cmd, r1_cmd, r0_addr, r1_addr, r0_wdata, r1_wdata, m_rdata,
    output r0_done, r1_done, r0_rdata, r1_rdata,
    output m_cmd, m_addr, m_wdata, owner, busy
  );

  modport slave (
    output r0_cmd, r1_cmd, r0_addr, r1_addr, r0_wdata, r1_wdata, m_rdata,
    input  r0_done, r1_done, r0_rdata, r1_rdata,
    input  m_cmd, m_addr, m_wdata, owner, busy
  );
endinterface

// File: rtl/vDFFE.sv
// Enable register with asynchronous active-low clear.
//   clk   : clock
//   reset : asynchronous active-low clear to zero
//   en    : load d on the rising edge when high, otherwise hold
//   d/q   : N-bit data in / registered data out
module vDFFE #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for a shared synchronous memory/I/O bus.
// Moore FSM IDLE -> ACCESS -> RESP -> IDLE: the bus command is driven for the
// single ACCESS cycle, done (and read data capture) happens in RESP.
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   bus       : mem_arbiter_if master modport (requesters + shared bus)
//   dbg_state : current FSM state
// Addresses are forwarded untouched, including the I/O half (bit AW-1 = 1).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 9
) (
  input  logic           clk,
  input  logic           reset,
  mem_arbiter_if.master  bus,
  output state_t         dbg_state
);

  state_t        state, state_next;
  logic          p0, p1;
  logic          grant_any;   // a grant happens on this edge
  logic          grant_sel;   // 1 = requester 1 wins
  logic          last_grant;  // round-robin pointer
  logic          owner_q;
  logic [1:0]    lat_cmd;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic [DW-1:0] rdata0, rdata1;

  assign p0 = is_req(bus.r0_cmd);
  assign p1 = is_req(bus.r1_cmd);

  // Requester 1 wins when it is alone, or on a tie when 0 was granted last.
  assign grant_sel = p1 & (~p0 | ~last_grant);
  assign grant_any = (state == IDLE) & (p0 | p1);

  // Latched request. m_addr/m_wdata come straight from these registers, so
  // they naturally hold their last values outside ACCESS.
  vDFFE #(.N(2)) u_lat_cmd (
    .clk(clk), .reset(reset), .en(grant_any),
    .d(grant_sel ? bus.r1_cmd : bus.r0_cmd), .q(lat_cmd)
  );
  vDFFE #(.N(AW)) u_lat_addr (
    .clk(clk), .reset(reset), .en(grant_any),
    .d(grant_sel ? bus.r1_addr : bus.r0_addr), .q(lat_addr)
  );
  vDFFE #(.N(DW)) u_lat_wdata (
    .clk(clk), .reset(reset), .en(grant_any),
    .d(grant_sel ? bus.r1_wdata : bus.r0_wdata), .q(lat_wdata)
  );

  // Reset points the round-robin pointer at requester 1 so requester 0 wins
  // the first tie, while owner itself reads 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (grant_any) begin
        owner_q    <= grant_sel;
        last_grant <= grant_sel;
      end
    end
  end

  always_comb begin
    state_next  = state;
    bus.m_cmd   = M_NONE;
    bus.r0_done = 1'b0;
    bus.r1_done = 1'b0;
    bus.busy    = 1'b1;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (p0 | p1) state_next = ACCESS;
      end
      ACCESS: begin
        bus.m_cmd  = lat_cmd;
        state_next = RESP;
      end
      RESP: begin
        bus.r0_done = ~owner_q;
        bus.r1_done = owner_q;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Synchronous RAM returns data during RESP; capture it for the owner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (state == RESP && lat_cmd == M_READ) begin
      if (owner_q) rdata1 <= bus.m_rdata;
      else         rdata0 <= bus.m_rdata;
    end
  end

  assign bus.m_addr   = lat_addr;
  assign bus.m_wdata  = lat_wdata;
  assign bus.r0_rdata = rdata0;
  assign bus.r1_rdata = rdata1;
  assign bus.owner    = owner_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed + light random bench for mem_arbiter. A monitor pops expected bus
// transactions and done pulses from queues filled when stimulus is driven.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int DW = 16;
  localparam int AW = 9;
  localparam int W  = 1 + 2 + AW + DW;  // {owner, cmd, addr, wdata}

  logic   clk;
  logic   reset;
  state_t dbg_state;

  mem_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  mem_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == 9'h005) return 16'hABCD;
    return 16'h5A00 ^ {7'd0, a};
  endfunction

  always @(posedge clk)
    if (bus.m_cmd == 2'b01) bus.m_rdata <= mem_word(bus.m_addr);

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];
  logic [1:0]   done_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    logic [1:0]   d;
    if (bus.m_cmd !== 2'b00) begin
      if (exp_q.size() == 0) chk("bus_unexpected_cmd", {30'd0, bus.m_cmd}, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("bus_txn", {4'd0, bus.owner, bus.m_cmd, bus.m_addr, bus.m_wdata}, {4'd0, e});
      end
    end
    if (bus.r0_done || bus.r1_done) begin
      if (done_q.size() == 0) chk("done_unexpected", {30'd0, bus.r1_done, bus.r0_done}, 32'd0);
      else begin
        d = done_q.pop_front();
        chk("done_vec", {30'd0, bus.r1_done, bus.r0_done}, {30'd0, d});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int k, input logic [1:0] cmd, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    if (k == 0) begin
      bus.r0_cmd = cmd; bus.r0_addr = a; bus.r0_wdata = d;
    end else begin
      bus.r1_cmd = cmd; bus.r1_addr = a; bus.r1_wdata = d;
    end
  endtask

  task automatic expect_txn(input int k, input logic [1:0] cmd, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input bit with_done);
    exp_q.push_back({k[0], cmd, a, d});
    if (with_done) done_q.push_back(k ? 2'b10 : 2'b01);
  endtask

  task automatic wait_done(input int k, output int cyc);
    logic seen;
    seen = 1'b0;
    cyc  = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      seen = (k == 0) ? bus.r0_done : bus.r1_done;
    end
    chk($sformatf("r%0d_done_seen", k), {31'd0, seen}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int cyc;
    int k;
    logic [1:0]    c;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    reset = 1'b0;
    bus.r0_cmd = 2'b00; bus.r0_addr = '0; bus.r0_wdata = '0;
    bus.r1_cmd = 2'b00; bus.r1_addr = '0; bus.r1_wdata = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_m_cmd",  {30'd0, bus.m_cmd}, 32'd0);
    chk("rst_m_addr", {23'd0, bus.m_addr}, 32'd0);
    chk("rst_busy",   {31'd0, bus.busy}, 32'd0);
    chk("rst_owner",  {31'd0, bus.owner}, 32'd0);
    chk("rst_rdata0", {16'd0, bus.r0_rdata}, 32'd0);
    chk("rst_state",  {30'd0, dbg_state}, {30'd0, IDLE});
    reset = 1'b1;

    // Single read by r0
    drive(0, M_READ, 9'h005, 16'h0000);
    expect_txn(0, M_READ, 9'h005, 16'h0000, 1);
    wait_done(0, cyc);
    chk("lat_r0_read", cyc, 32'd2);
    drive(0, M_NONE, 9'h005, 16'h0000);
    @(negedge clk);
    chk("r0_rdata_read", {16'd0, bus.r0_rdata}, 32'h0000ABCD);
    chk("m_addr_hold", {23'd0, bus.m_addr}, 32'h005);
    chk("m_cmd_idle", {30'd0, bus.m_cmd}, 32'd0);

    // Tie right after reset: r0 must win, r1 three cycles later
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    drive(0, M_WRITE, 9'h010, 16'h1234);
    drive(1, M_READ,  9'h011, 16'h0000);
    expect_txn(0, M_WRITE, 9'h010, 16'h1234, 1);
    expect_txn(1, M_READ,  9'h011, 16'h0000, 1);
    wait_done(0, cyc);
    chk("lat_tie_r0", cyc, 32'd2);
    drive(0, M_NONE, 9'h010, 16'h1234);
    wait_done(1, cyc);
    chk("tie_r1_gap", cyc, 32'd3);
    drive(1, M_NONE, 9'h011, 16'h0000);
    @(negedge clk);
    chk("r1_rdata_tie", {16'd0, bus.r1_rdata}, {16'd0, mem_word(9'h011)});
    chk("r0_rdata_after_write", {16'd0, bus.r0_rdata}, 32'd0);

    // Continuous contention for 12 cycles
    drive(0, M_READ,  9'h020, 16'h0000);
    drive(1, M_WRITE, 9'h021, 16'h5555);
    for (int i = 0; i < 2; i++) begin
      expect_txn(0, M_READ,  9'h020, 16'h0000, 1);
      expect_txn(1, M_WRITE, 9'h021, 16'h5555, 1);
    end
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk($sformatf("owner_rr_%0d", i), {31'd0, bus.owner}, ((i - 1) / 3) % 2);
      chk($sformatf("busy_rr_%0d", i), {31'd0, bus.busy}, {31'd0, (i % 3) != 0});
    end
    drive(0, M_NONE, 9'h020, 16'h0000);
    drive(1, M_NONE, 9'h021, 16'h5555);
    @(negedge clk);
    chk("r0_rdata_rr", {16'd0, bus.r0_rdata}, {16'd0, mem_word(9'h020)});
    chk("r1_rdata_hold", {16'd0, bus.r1_rdata}, {16'd0, mem_word(9'h011)});

    // Invalid command 11 gets no grant
    bus.r1_cmd = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("busy_cmd11", {31'd0, bus.busy}, 32'd0);
    end

    // I/O address forwarded unchanged, r0 parked on 11
    bus.r0_cmd = 2'b11;
    drive(1, M_WRITE, 9'h1FF, 16'hBEEF);
    expect_txn(1, M_WRITE, 9'h1FF, 16'hBEEF, 1);
    wait_done(1, cyc);
    chk("lat_io_write", cyc, 32'd2);
    bus.r0_cmd = 2'b00;
    drive(1, M_NONE, 9'h1FF, 16'hBEEF);
    @(negedge clk);
    chk("m_addr_io_hold", {23'd0, bus.m_addr}, 32'h1FF);

    // A few random single transactions
    for (int n = 0; n < 4; n++) begin
      k = $urandom_range(0, 1);
      c = $urandom_range(1, 2);
      a = AW'($urandom_range(0, 511));
      d = DW'($urandom_range(0, 65535));
      drive(k, c, a, d);
      expect_txn(k, c, a, d, 1);
      wait_done(k, cyc);
      chk("lat_rand", cyc, 32'd2);
      drive(k, M_NONE, a, d);
      @(negedge clk);
      if (c == M_READ)
        chk("rdata_rand", {16'd0, (k == 0) ? bus.r0_rdata : bus.r1_rdata}, {16'd0, mem_word(a)});
    end

    // Reset during ACCESS drops the transaction
    drive(0, M_WRITE, 9'h030, 16'h0F0F);
    expect_txn(0, M_WRITE, 9'h030, 16'h0F0F, 0);
    @(negedge clk);
    chk("state_access", {30'd0, dbg_state}, {30'd0, ACCESS});
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_m_cmd", {30'd0, bus.m_cmd}, 32'd0);
    chk("rst_mid_busy",  {31'd0, bus.busy}, 32'd0);
    chk("rst_mid_done",  {31'd0, bus.r0_done}, 32'd0);
    drive(0, M_NONE, 9'h030, 16'h0F0F);
    @(negedge clk);
    chk("rst_mid_done2", {31'd0, bus.r0_done}, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_after_rst", {31'd0, bus.busy}, 32'd0);
    end

    chk("exp_q_empty",  exp_q.size(), 32'd0);
    chk("done_q_empty", done_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
